product_accumulator: RTL

//  Downstream consumer of the 8x8 multiplier's 16-bit product (MAC back end).

---
 rtl/product_accumulator.sv | 110 +++++++++++
 1 files changed

// File: rtl/product_accumulator.sv
// product_accumulator: back end of a MAC. It sums a programmable-length run of
// unsigned products into one wide register. Each finished sum is handed downstream
// on a valid/ready handshake, together with a sticky overflow flag.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i, len_i         begin a run of len_i products (sampled in idle only)
//   product_i              unsigned product from the multiplier
//   product_valid_i        product_i valid
//   product_ready_o        product accepted (decoded from state only)
//   acc_o, overflow_o      registered sum and sticky carry-out flag
//   acc_valid_o            acc_o holds a completed run
//   acc_ready_i            downstream takes acc_o
//   busy_o                 run in progress or result pending
module product_accumulator #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  len_i,
  input  logic [PROD_W-1:0] product_i,
  input  logic              product_valid_i,
  output logic              product_ready_o,
  output logic [ACC_W-1:0]  acc_o,
  output logic              acc_valid_o,
  input  logic              acc_ready_i,
  output logic              overflow_o,
  output logic              busy_o
);

  localparam int unsigned SumW = ACC_W + 1;

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic [SumW-1:0]  sum;

  // One bit wider than the accumulator so the carry out is visible.
  assign sum = {1'b0, acc_q} + SumW'(product_i);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          acc_d = '0;
          ovf_d = 1'b0;
          cnt_d = '0;
          if (len_i == '0) begin
            // An empty run goes straight to a zero result.
            state_d = StDone;
          end else begin
            len_d   = len_i;
            state_d = StAccum;
          end
        end
      end
      StAccum: begin
        if (product_valid_i) begin
          acc_d = sum[ACC_W-1:0];
          ovf_d = ovf_q | sum[ACC_W];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == len_q - CNT_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (acc_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  assign product_ready_o = (state_q == StAccum);
  assign acc_valid_o     = (state_q == StDone);
  assign busy_o          = (state_q == StAccum) || (state_q == StDone);
  assign acc_o           = acc_q;
  assign overflow_o      = ovf_q;

endmodule
